if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 10 +
 rtl/if_stage.sv | 106 ++++++++++
 tb/tb_if_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_stage_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  modport master (output imem_read, output imem_address, input imem_rdata, input imem_resp);
  modport slave  (input imem_read, input imem_address, output imem_rdata, output imem_resp);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: pc register, single outstanding imem request,
// stall buffer and IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_pc_mux_sel,
  input  logic [31:0] ID_jmp_pc,
  input  logic        flush,
  input  logic        stall,
  if_stage_if.master  imem,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_instr,
  output logic        IF_ID_valid,
  output logic        IF_busy
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] buf_instr;
  logic [XLEN-1:0] buf_pc;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_inc;

  assign target  = {ID_jmp_pc[31:2], 2'b00};
  assign pc_inc  = pc + XLEN'(4);
  assign IF_busy = imem.imem_read & ~imem.imem_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= FETCH;
      pc                <= RESET_PC;
      buf_instr         <= '0;
      buf_pc            <= '0;
      IF_ID_pc          <= '0;
      IF_ID_instr       <= NOP;
      IF_ID_valid       <= 1'b0;
      imem.imem_read    <= 1'b1;
      imem.imem_address <= RESET_PC;
    end else begin
      // IF/ID takes a bubble unless held by stall; a load below overrides
      if (!stall) begin
        IF_ID_valid <= 1'b0;
        IF_ID_instr <= NOP;
      end
      case (state)
        FETCH: begin
          if (ID_pc_mux_sel) begin
            pc <= target;
            if (imem.imem_resp) imem.imem_address <= target;
            else                state <= DROP;
          end else if (imem.imem_resp) begin
            if (stall || flush) begin
              buf_instr      <= imem.imem_rdata;
              buf_pc         <= pc;
              imem.imem_read <= 1'b0;
              state          <= HOLD;
            end else begin
              IF_ID_valid       <= 1'b1;
              IF_ID_instr       <= imem.imem_rdata;
              IF_ID_pc          <= pc;
              pc                <= pc_inc;
              imem.imem_address <= pc_inc;
            end
          end
        end
        HOLD: begin
          if (ID_pc_mux_sel) begin
            pc                <= target;
            imem.imem_address <= target;
            imem.imem_read    <= 1'b1;
            state             <= FETCH;
          end else if (!stall && !flush) begin
            IF_ID_valid       <= 1'b1;
            IF_ID_instr       <= buf_instr;
            IF_ID_pc          <= buf_pc;
            pc                <= pc_inc;
            imem.imem_address <= pc_inc;
            imem.imem_read    <= 1'b1;
            state             <= FETCH;
          end
        end
        DROP: begin
          // old address stays on the bus until its response is swallowed
          if (ID_pc_mux_sel) pc <= target;
          if (imem.imem_resp) begin
            imem.imem_address <= ID_pc_mux_sel ? target : pc;
            state             <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
      if (flush) begin
        IF_ID_valid <= 1'b0;
        IF_ID_instr <= NOP;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage: each record drives one cycle and
// checks bus outputs before the edge and IF/ID after it.
module tb_if_stage;

  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        rst;
    logic        sel;
    logic [31:0] jmp;
    logic        flush;
    logic        stall;
    logic        resp;
    logic [31:0] rdata;
    logic        chk_pre;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_busy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_pc_mux_sel;
  logic [31:0] ID_jmp_pc;
  logic        flush;
  logic        stall;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_instr;
  logic        IF_ID_valid;
  logic        IF_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int row   = 0;

  if_stage_if bus ();

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ID_pc_mux_sel (ID_pc_mux_sel),
    .ID_jmp_pc     (ID_jmp_pc),
    .flush         (flush),
    .stall         (stall),
    .imem          (bus.master),
    .IF_ID_pc      (IF_ID_pc),
    .IF_ID_instr   (IF_ID_instr),
    .IF_ID_valid   (IF_ID_valid),
    .IF_busy       (IF_busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic s, input logic [31:0] j,
                              input logic f, input logic st, input logic rs,
                              input logic [31:0] rd, input logic cp, input logic er,
                              input logic [31:0] ea, input logic eb, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.sel = s; v.jmp = j; v.flush = f; v.stall = st; v.resp = rs;
    v.rdata = rd; v.chk_pre = cp; v.e_read = er; v.e_addr = ea; v.e_busy = eb;
    v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s row%0d: got %h want %h", name, row, got, exp);
    end
  endtask

  task automatic run(input vec_t v);
    rst = v.rst; ID_pc_mux_sel = v.sel; ID_jmp_pc = v.jmp;
    flush = v.flush; stall = v.stall;
    bus.imem_resp = v.resp; bus.imem_rdata = v.rdata;
    #1;
    if (v.chk_pre) begin
      check("imem_read", 32'(bus.imem_read), 32'(v.e_read));
      check("IF_busy", 32'(IF_busy), 32'(v.e_busy));
      if (v.e_read) check("imem_address", bus.imem_address, v.e_addr);
    end
    @(posedge clk);
    #1;
    check("IF_ID_valid", 32'(IF_ID_valid), 32'(v.e_valid));
    check("IF_ID_instr", IF_ID_instr, v.e_instr);
    check("IF_ID_pc", IF_ID_pc, v.e_pc);
    row++;
  endtask

  vec_t tbl[$];

  initial begin
    // reset
    tbl.push_back(mk(1,0,0,0,0,0,0,      0,0,0,0,          0,32'h0,NOP));
    // streaming, one response per cycle
    tbl.push_back(mk(0,0,0,0,0,1,K^32'h60, 1,1,32'h60,0,   1,32'h60,K^32'h60));
    tbl.push_back(mk(0,0,0,0,0,1,K^32'h64, 1,1,32'h64,0,   1,32'h64,K^32'h64));
    tbl.push_back(mk(0,0,0,0,0,1,K^32'h68, 1,1,32'h68,0,   1,32'h68,K^32'h68));
    // three-cycle latency: bubbles, busy, fixed address
    tbl.push_back(mk(0,0,0,0,0,0,0,      1,1,32'h6C,1,     0,32'h68,NOP));
    tbl.push_back(mk(0,0,0,0,0,0,0,      1,1,32'h6C,1,     0,32'h68,NOP));
    tbl.push_back(mk(0,0,0,0,0,0,0,      1,1,32'h6C,1,     0,32'h68,NOP));
    tbl.push_back(mk(0,0,0,0,0,1,K^32'h6C, 1,1,32'h6C,0,   1,32'h6C,K^32'h6C));
    // response under stall: HOLD with read low, IF/ID frozen
    tbl.push_back(mk(0,0,0,0,1,1,K^32'h70, 1,1,32'h70,0,   1,32'h6C,K^32'h6C));
    tbl.push_back(mk(0,0,0,0,1,0,0,      1,0,0,0,          1,32'h6C,K^32'h6C));
    tbl.push_back(mk(0,0,0,0,0,0,0,      1,0,0,0,          1,32'h70,K^32'h70));
    // redirect to 0x203 while 0x74 outstanding
    tbl.push_back(mk(0,1,32'h203,0,0,0,0, 1,1,32'h74,1,    0,32'h70,NOP));
    tbl.push_back(mk(0,0,0,0,0,0,0,      1,1,32'h74,1,     0,32'h70,NOP));
    tbl.push_back(mk(0,0,0,0,0,1,K^32'h74, 1,1,32'h74,0,   0,32'h70,NOP));
    tbl.push_back(mk(0,0,0,0,0,1,K^32'h200, 1,1,32'h200,0, 1,32'h200,K^32'h200));
    // flush with stall kills valid
    tbl.push_back(mk(0,0,0,1,1,0,0,      1,1,32'h204,1,    0,32'h200,NOP));
    // flush on arriving word: word parked in buffer, delivered next cycle
    tbl.push_back(mk(0,0,0,1,0,1,K^32'h204, 1,1,32'h204,0, 0,32'h200,NOP));
    tbl.push_back(mk(0,0,0,0,0,0,0,      1,0,0,0,          1,32'h204,K^32'h204));

    foreach (tbl[i]) run(tbl[i]);

    // wrap: redirect to 0xFFFFFFFC (low bits masked), then fetch across zero
    run(mk(0,1,32'hFFFF_FFFF,0,0,1,32'hDEAD_BEEF, 1,1,32'h208,0, 0,32'h204,NOP));
    run(mk(0,0,0,0,0,1,K^32'hFFFF_FFFC, 1,1,32'hFFFF_FFFC,0, 1,32'hFFFF_FFFC,K^32'hFFFF_FFFC));
    run(mk(0,0,0,0,0,1,K^32'h0,          1,1,32'h0,0,          1,32'h0,K^32'h0));

    // reset while in DROP; the late response belongs to the fetch at RESET_PC
    run(mk(0,1,32'h300,0,0,0,0,   1,1,32'h4,1,  0,32'h0,NOP));
    run(mk(1,0,0,0,0,0,0,         1,1,32'h4,1,  0,32'h0,NOP));
    run(mk(0,0,0,0,0,1,K^32'h60,  1,1,32'h60,0, 1,32'h60,K^32'h60));
    run(mk(0,0,0,0,0,1,K^32'h64,  1,1,32'h64,0, 1,32'h64,K^32'h64));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
